// File: rtl/adder_2bit.sv
// rtl/adder_2bit.sv - 2-bit unsigned adder with registered result and saturating overflow counter
// Combinational sum/carry path plus a one-cycle registered copy gated by in_valid.
module adder_2bit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  input  logic             in_valid,
  output logic [1:0]       sum,
  output logic             carry_out,
  output logic [1:0]       sum_q,
  output logic             carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] ovf_count
);

  logic [2:0]       w_total;
  logic             w_ovf_sat;
  logic [1:0]       r_sum_q;
  logic             r_carry_q;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_ovf_count;

  // Zero-extend so bit 2 carries the overflow of the 2-bit add.
  assign w_total   = {1'b0, a} + {1'b0, b};
  assign sum       = w_total[1:0];
  assign carry_out = w_total[2];
  assign w_ovf_sat = &r_ovf_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_q     <= 2'b00;
      r_carry_q   <= 1'b0;
      r_out_valid <= 1'b0;
      r_ovf_count <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum_q   <= sum;
        r_carry_q <= carry_out;
        // Counter sticks at all-ones rather than wrapping.
        if (carry_out && !w_ovf_sat) begin
          r_ovf_count <= r_ovf_count + CNT_W'(1);
        end
      end
    end
  end

  assign sum_q     = r_sum_q;
  assign carry_q   = r_carry_q;
  assign out_valid = r_out_valid;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_adder_2bit.sv
// tb/tb_adder_2bit.sv - directed self-checking bench for adder_2bit
// Two instances share stimulus: default counter width and a 2-bit counter for saturation.
module tb_adder_2bit;

  logic       clk;
  logic       rst_n;
  logic [1:0] a;
  logic [1:0] b;
  logic       in_valid;

  logic [1:0] sum8, sum_q8, sum2, sum_q2;
  logic       carry_out8, carry_q8, out_valid8;
  logic       carry_out2, carry_q2, out_valid2;
  logic [7:0] ovf_count8;
  logic [1:0] ovf_count2;

  int n_assert = 0;
  int n_fail   = 0;

  adder_2bit #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .sum(sum8), .carry_out(carry_out8), .sum_q(sum_q8), .carry_q(carry_q8),
    .out_valid(out_valid8), .ovf_count(ovf_count8)
  );

  adder_2bit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .sum(sum2), .carry_out(carry_out2), .sum_q(sum_q2), .carry_q(carry_q2),
    .out_valid(out_valid2), .ovf_count(ovf_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input int s, input int c, input int v,
                          input int o8, input int o2);
    chk({tag, " sum_q8"},     32'(sum_q8),     32'(s));
    chk({tag, " carry_q8"},   32'(carry_q8),   32'(c));
    chk({tag, " out_valid8"}, 32'(out_valid8), 32'(v));
    chk({tag, " ovf_count8"}, 32'(ovf_count8), 32'(o8));
    chk({tag, " sum_q2"},     32'(sum_q2),     32'(s));
    chk({tag, " carry_q2"},   32'(carry_q2),   32'(c));
    chk({tag, " out_valid2"}, 32'(out_valid2), 32'(v));
    chk({tag, " ovf_count2"}, 32'(ovf_count2), 32'(o2));
  endtask

  task automatic chk_comb(input string tag, input int s, input int c);
    chk({tag, " sum8"},   32'(sum8),       32'(s));
    chk({tag, " carry8"}, 32'(carry_out8), 32'(c));
    chk({tag, " sum2"},   32'(sum2),       32'(s));
    chk({tag, " carry2"}, 32'(carry_out2), 32'(c));
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a = 2'(i);
        b = 2'(j);
        #1;
        chk_comb($sformatf("%s %0d+%0d", tag, i, j), (i + j) % 4, (i + j) / 4);
      end
    end
  endtask

  task automatic accept(input logic [1:0] av, input logic [1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    a = 2'd0;
    b = 2'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a = 2'd0;
    b = 2'd0;
    in_valid = 1'b0;
    #10;
    chk_regs("reset", 0, 0, 0, 0, 0);

    a = 2'd0; b = 2'd0; #10; chk_comb("0+0", 0, 0);
    a = 2'd1; b = 2'd1; #10; chk_comb("1+1", 2, 0);
    a = 2'd3; b = 2'd2; #10; chk_comb("3+2", 1, 1);
    a = 2'd3; b = 2'd3; #10; chk_comb("3+3", 2, 1);

    sweep("sweep_rst");
    @(negedge clk);
    rst_n = 1'b1;
    sweep("sweep_run");
    chk_regs("post_sweep", 0, 0, 0, 0, 0);

    accept(2'd3, 2'd2);
    chk_regs("acc 3+2", 1, 1, 1, 1, 1);
    idle_cycle();
    chk_regs("hold1", 1, 1, 0, 1, 1);
    idle_cycle();
    chk_regs("hold2", 1, 1, 0, 1, 1);

    reset_pulse();
    #1;
    chk_regs("clear", 0, 0, 0, 0, 0);
    accept(2'd3, 2'd3); chk_regs("sat1", 2, 1, 1, 1, 1);
    accept(2'd3, 2'd3); chk_regs("sat2", 2, 1, 1, 2, 2);
    accept(2'd3, 2'd3); chk_regs("sat3", 2, 1, 1, 3, 3);
    accept(2'd3, 2'd3); chk_regs("sat4", 2, 1, 1, 4, 3);
    accept(2'd3, 2'd3); chk_regs("sat5", 2, 1, 1, 5, 3);
    accept(2'd1, 2'd0); chk_regs("sat_nocarry", 1, 0, 1, 5, 3);
    idle_cycle();

    reset_pulse();
    accept(2'd2, 2'd3);
    accept(2'd3, 2'd1);
    chk_regs("pre_rst", 0, 1, 1, 2, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_regs("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_regs("rst_edge", 0, 0, 0, 0, 0);
    @(negedge clk);
    a = 2'd1;
    b = 2'd1;
    in_valid = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_regs("first_acc", 2, 0, 1, 0, 0);
    idle_cycle();
    chk_regs("first_hold", 2, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
